id_stage: RTL and testbench

ID_STAGE -- requirements
Module: id_stage

---
 rtl/id_stage_pkg.sv | 46 ++++
 rtl/id_stage_imm_gen.sv | 28 ++
 rtl/id_stage.sv | 163 ++++++++++++++++
 tb/tb_id_stage.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/id_stage_pkg.sv
// Shared definitions for the RV32I decode stage: bus widths, opcodes,
// ALU selector encoding, stage state encoding and the operand-forwarding mux.
package id_stage_pkg;

    localparam int unsigned REG_BUS      = 32;
    localparam int unsigned REG_ADDR_BUS = 5;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
    } alusel_e;

    typedef enum logic [1:0] {
        ST_RUN, ST_STALL, ST_HOLD
    } state_e;

    // Disabled ports and x0 read as zero; EX wins over MEM except for a pending load.
    function automatic logic [REG_BUS-1:0] fwd_operand(
        input logic                    en,
        input logic [REG_ADDR_BUS-1:0] addr,
        input logic [REG_BUS-1:0]      rdata,
        input logic                    ex_we,
        input logic [REG_ADDR_BUS-1:0] ex_addr,
        input logic [REG_BUS-1:0]      ex_data,
        input logic                    ex_load,
        input logic                    mem_we,
        input logic [REG_ADDR_BUS-1:0] mem_addr,
        input logic [REG_BUS-1:0]      mem_data
    );
        if (!en || addr == '0)                         return '0;
        else if (ex_we && !ex_load && ex_addr == addr) return ex_data;
        else if (mem_we && mem_addr == addr)           return mem_data;
        else                                           return rdata;
    endfunction

endpackage

// File: rtl/id_stage_imm_gen.sv
// RV32I immediate generator: selects the I/S/B/U/J format from the opcode
// and sign-extends to 32 bits; formats without an immediate yield zero.
module imm_gen
    import id_stage_pkg::*;
(
    input  logic [REG_BUS-1:0] inst,
    output logic [REG_BUS-1:0] imm
);

    always_comb begin
        imm = '0;
        case (inst[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR:
                imm = {{20{inst[31]}}, inst[31:20]};
            OPC_STORE:
                imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            OPC_BRANCH:
                imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm = {inst[31:12], 12'b0};
            OPC_JAL:
                imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

endmodule

// File: rtl/id_stage.sv
// RV32I instruction decode stage: combinational decode and operand forwarding,
// load-use stall detection, and the registered ID/EX pipeline payload.
module id_stage
    import id_stage_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_valid,
    input  logic [REG_BUS-1:0]      if_pc,
    input  logic [REG_BUS-1:0]      if_inst,
    output logic                    id_ready,
    output logic                    re1,
    output logic [REG_ADDR_BUS-1:0] raddr1,
    input  logic [REG_BUS-1:0]      rdata1,
    output logic                    re2,
    output logic [REG_ADDR_BUS-1:0] raddr2,
    input  logic [REG_BUS-1:0]      rdata2,
    input  logic                    ex_fwd_we,
    input  logic [REG_ADDR_BUS-1:0] ex_fwd_addr,
    input  logic [REG_BUS-1:0]      ex_fwd_data,
    input  logic                    ex_fwd_load,
    input  logic                    mem_fwd_we,
    input  logic [REG_ADDR_BUS-1:0] mem_fwd_addr,
    input  logic [REG_BUS-1:0]      mem_fwd_data,
    input  logic                    flush,
    input  logic                    ex_ready,
    output logic                    ex_valid,
    output logic [REG_BUS-1:0]      ex_pc,
    output logic [REG_BUS-1:0]      ex_op1,
    output logic [REG_BUS-1:0]      ex_op2,
    output logic [REG_BUS-1:0]      ex_imm,
    output logic [3:0]              ex_alusel,
    output logic [2:0]              ex_funct3,
    output logic                    ex_wreg,
    output logic [REG_ADDR_BUS-1:0] ex_waddr,
    output logic                    ex_illegal,
    output logic [REG_BUS-1:0]      stall_cnt
);

    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [4:0]         rd;
    logic               alt;
    logic               legal;
    logic               writes;
    logic               dec_wreg;
    alusel_e            dec_alusel;
    logic [REG_BUS-1:0] dec_imm;
    logic [REG_BUS-1:0] op1;
    logic [REG_BUS-1:0] op2;
    logic               hazard;
    logic               load_en;
    logic               fire;
    state_e             state;
    state_e             state_next;

    assign opcode = if_inst[6:0];
    assign funct3 = if_inst[14:12];
    assign rd     = if_inst[11:7];
    assign alt    = if_inst[30];
    assign raddr1 = if_inst[19:15];
    assign raddr2 = if_inst[24:20];

    imm_gen u_imm_gen (
        .inst (if_inst),
        .imm  (dec_imm)
    );

    always_comb begin
        legal      = 1'b1;
        re1        = 1'b0;
        re2        = 1'b0;
        writes     = 1'b0;
        dec_alusel = ALU_ADD;
        case (opcode)
            OPC_OP, OPC_OP_IMM: begin
                re1    = 1'b1;
                re2    = (opcode == OPC_OP);
                writes = 1'b1;
                case (funct3)
                    3'b000:  dec_alusel = (opcode == OPC_OP && alt) ? ALU_SUB : ALU_ADD;
                    3'b001:  dec_alusel = ALU_SLL;
                    3'b010:  dec_alusel = ALU_SLT;
                    3'b011:  dec_alusel = ALU_SLTU;
                    3'b100:  dec_alusel = ALU_XOR;
                    3'b101:  dec_alusel = alt ? ALU_SRA : ALU_SRL;
                    3'b110:  dec_alusel = ALU_OR;
                    default: dec_alusel = ALU_AND;
                endcase
            end
            OPC_LUI: begin
                writes     = 1'b1;
                dec_alusel = ALU_PASSB;
            end
            OPC_AUIPC, OPC_JAL: writes = 1'b1;
            OPC_LOAD, OPC_JALR: begin
                re1    = 1'b1;
                writes = 1'b1;
            end
            OPC_STORE, OPC_BRANCH: begin
                re1 = 1'b1;
                re2 = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    assign dec_wreg = writes && (rd != '0);

    assign op1 = fwd_operand(re1, raddr1, rdata1, ex_fwd_we, ex_fwd_addr, ex_fwd_data,
                             ex_fwd_load, mem_fwd_we, mem_fwd_addr, mem_fwd_data);
    assign op2 = fwd_operand(re2, raddr2, rdata2, ex_fwd_we, ex_fwd_addr, ex_fwd_data,
                             ex_fwd_load, mem_fwd_we, mem_fwd_addr, mem_fwd_data);

    assign hazard = if_valid && ex_fwd_load && ex_fwd_we && (ex_fwd_addr != '0) &&
                    ((re1 && ex_fwd_addr == raddr1) || (re2 && ex_fwd_addr == raddr2));

    assign id_ready = !rst && !flush && !hazard && (!ex_valid || ex_ready);
    assign fire     = if_valid && id_ready;
    // The ID/EX register freezes only while EX back-pressures; flush still clears it.
    assign load_en  = flush || !ex_valid || ex_ready;

    always_comb begin
        state_next = ST_RUN;
        if (flush)                    state_next = ST_RUN;
        else if (ex_valid && !ex_ready) state_next = ST_HOLD;
        else if (hazard)              state_next = ST_STALL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_RUN;
            stall_cnt  <= '0;
            ex_valid   <= 1'b0;
            ex_pc      <= '0;
            ex_op1     <= '0;
            ex_op2     <= '0;
            ex_imm     <= '0;
            ex_alusel  <= '0;
            ex_funct3  <= '0;
            ex_wreg    <= 1'b0;
            ex_waddr   <= '0;
            ex_illegal <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ST_STALL && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (load_en) begin
                ex_valid   <= fire;
                ex_pc      <= if_pc;
                ex_op1     <= op1;
                ex_op2     <= op2;
                ex_imm     <= dec_imm;
                ex_alusel  <= dec_alusel;
                ex_funct3  <= funct3;
                ex_wreg    <= dec_wreg && fire;
                ex_waddr   <= rd;
                ex_illegal <= !legal && fire;
            end
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: directed instructions push hand-computed
// ID/EX payloads; a monitor pops and compares each newly presented payload.
module tb_id_stage;
    import id_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        id_ready;
    logic        re1, re2;
    logic [4:0]  raddr1, raddr2;
    logic [31:0] rdata1, rdata2;
    logic        ex_fwd_we, ex_fwd_load, mem_fwd_we;
    logic [4:0]  ex_fwd_addr, mem_fwd_addr;
    logic [31:0] ex_fwd_data, mem_fwd_data;
    logic        flush, ex_ready;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_op1, ex_op2, ex_imm;
    logic [3:0]  ex_alusel;
    logic [2:0]  ex_funct3;
    logic        ex_wreg, ex_illegal;
    logic [4:0]  ex_waddr;
    logic [31:0] stall_cnt;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic [2:0]  f3;
        logic        wreg;
        logic [4:0]  waddr;
        logic        ill;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] rf [32];
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    always_comb rdata1 = rf[raddr1];
    always_comb rdata2 = rf[raddr2];

    id_stage dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
        .id_ready(id_ready), .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
        .ex_fwd_we(ex_fwd_we), .ex_fwd_addr(ex_fwd_addr), .ex_fwd_data(ex_fwd_data),
        .ex_fwd_load(ex_fwd_load), .mem_fwd_we(mem_fwd_we), .mem_fwd_addr(mem_fwd_addr),
        .mem_fwd_data(mem_fwd_data), .flush(flush), .ex_ready(ex_ready),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op1(ex_op1), .ex_op2(ex_op2),
        .ex_imm(ex_imm), .ex_alusel(ex_alusel), .ex_funct3(ex_funct3),
        .ex_wreg(ex_wreg), .ex_waddr(ex_waddr), .ex_illegal(ex_illegal),
        .stall_cnt(stall_cnt)
    );

    function automatic exp_t mk(input logic [31:0] pc, op1, op2, imm, input logic [3:0] alu,
                                input logic [2:0] f3, input logic wreg, input logic [4:0] waddr,
                                input logic ill);
        mk = '{pc: pc, op1: op1, op2: op2, imm: imm, alu: alu, f3: f3,
               wreg: wreg, waddr: waddr, ill: ill};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst);
        if_valid = v;
        if_pc    = pc;
        if_inst  = inst;
    endtask

    task automatic clear_fwd();
        ex_fwd_we = 0; ex_fwd_addr = '0; ex_fwd_data = '0; ex_fwd_load = 0;
        mem_fwd_we = 0; mem_fwd_addr = '0; mem_fwd_data = '0;
    endtask

    // Monitor: a payload is new when the register was allowed to load at this edge.
    always @(posedge clk) begin
        logic ld;
        exp_t e, act;
        ld = !rst && (flush || !ex_valid || ex_ready);
        #1;
        if (ld && ex_valid) begin
            vectors++;
            act = '{pc: ex_pc, op1: ex_op1, op2: ex_op2, imm: ex_imm, alu: ex_alusel,
                    f3: ex_funct3, wreg: ex_wreg, waddr: ex_waddr, ill: ex_illegal};
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL sb_unexpected: got pc=%h with no expected entry", ex_pc);
            end else begin
                e = sb.pop_front();
                if (act !== e) begin
                    miscompares++;
                    $display("FAIL payload pc=%h: got op1=%h op2=%h imm=%h alu=%0d f3=%0d wreg=%b waddr=%0d ill=%b, expected pc=%h op1=%h op2=%h imm=%h alu=%0d f3=%0d wreg=%b waddr=%0d ill=%b",
                             act.pc, act.op1, act.op2, act.imm, act.alu, act.f3, act.wreg, act.waddr, act.ill,
                             e.pc, e.op1, e.op2, e.imm, e.alu, e.f3, e.wreg, e.waddr, e.ill);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = {4{i[7:0]}};
        rf[1] = 32'h1111_1111;
        rf[2] = 32'h2222_4444;
        rst = 1; flush = 0; ex_ready = 1;
        clear_fwd();
        drive(1, 32'h0, 32'h0001_02B3);

        // Reset: id_ready low during rst, registers cleared after
        @(negedge clk);
        #1 chk("rst_id_ready", {31'b0, id_ready}, 0);
        @(negedge clk);
        chk("rst_ex_valid", {31'b0, ex_valid}, 0);
        chk("rst_ex_wreg", {31'b0, ex_wreg}, 0);
        chk("rst_ex_op1", ex_op1, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        rst = 0;
        drive(0, 0, 0);

        // ADD x5,x2,x0 from the register file
        @(negedge clk);
        drive(1, 32'h100, 32'h0001_02B3);
        sb.push_back(mk(32'h100, 32'h2222_4444, 0, 0, ALU_ADD, 0, 1, 5, 0));
        #1 chk("add_id_ready", {31'b0, id_ready}, 1);

        // ADD x6,x2,x2 with EX and MEM both forwarding x2: EX wins
        @(negedge clk);
        drive(1, 32'h104, 32'h0021_0333);
        ex_fwd_we = 1; ex_fwd_addr = 2; ex_fwd_data = 32'h1;
        mem_fwd_we = 1; mem_fwd_addr = 2; mem_fwd_data = 32'h2;
        sb.push_back(mk(32'h104, 32'h1, 32'h1, 0, ALU_ADD, 0, 1, 6, 0));

        // Load-use: LW x7 in EX, ADD x8,x7,x1 must stall one cycle
        @(negedge clk);
        clear_fwd();
        drive(1, 32'h108, 32'h0013_8433);
        ex_fwd_we = 1; ex_fwd_addr = 7; ex_fwd_data = 32'hDEAD_BEEF; ex_fwd_load = 1;
        #1 chk("loaduse_id_ready", {31'b0, id_ready}, 0);
        @(negedge clk);
        chk("loaduse_bubble", {31'b0, ex_valid}, 0);
        clear_fwd();
        mem_fwd_we = 1; mem_fwd_addr = 7; mem_fwd_data = 32'h77;
        sb.push_back(mk(32'h108, 32'h77, 32'h1111_1111, 0, ALU_ADD, 0, 1, 8, 0));
        #1 chk("loaduse_release", {31'b0, id_ready}, 1);

        @(negedge clk);
        chk("loaduse_stall_cnt", stall_cnt, 1);
        clear_fwd();
        drive(1, 32'h10C, 32'h4041_84B3);
        sb.push_back(mk(32'h10C, 32'h0303_0303, 32'h0404_0404, 0, ALU_SUB, 0, 1, 9, 0));
        @(negedge clk);
        drive(1, 32'h110, 32'h0050_8013);
        sb.push_back(mk(32'h110, 32'h1111_1111, 0, 5, ALU_ADD, 0, 0, 0, 0));
        @(negedge clk);
        drive(1, 32'h114, 32'h0000_007F);
        sb.push_back(mk(32'h114, 0, 0, 0, ALU_ADD, 0, 0, 0, 1));
        @(negedge clk);
        drive(1, 32'h118, 32'h1234_5537);
        sb.push_back(mk(32'h118, 0, 0, 32'h1234_5000, ALU_PASSB, 5, 1, 10, 0));
        @(negedge clk);
        drive(1, 32'h11C, 32'hFE20_8CE3);
        sb.push_back(mk(32'h11C, 32'h1111_1111, 32'h2222_4444, 32'hFFFF_FFF8, ALU_ADD, 0, 0, 25, 0));
        @(negedge clk);
        drive(1, 32'h120, 32'hFE53_2E23);
        sb.push_back(mk(32'h120, 32'h0606_0606, 32'h0505_0505, 32'hFFFF_FFFC, ALU_ADD, 2, 0, 28, 0));
        @(negedge clk);
        drive(1, 32'h124, 32'h0100_00EF);
        sb.push_back(mk(32'h124, 0, 0, 32'h10, ALU_ADD, 0, 1, 1, 0));
        @(negedge clk);
        drive(1, 32'h128, 32'h4036_5593);
        sb.push_back(mk(32'h128, 32'h0C0C_0C0C, 0, 32'h403, ALU_SRA, 5, 1, 11, 0));

        // Back-pressure: EX stalls 3 cycles, payload must hold
        @(negedge clk);
        drive(1, 32'h200, 32'h0001_02B3);
        sb.push_back(mk(32'h200, 32'h2222_4444, 0, 0, ALU_ADD, 0, 1, 5, 0));
        @(negedge clk);
        drive(1, 32'h204, 32'h0021_0333);
        ex_ready = 0;
        #1 chk("hold_id_ready_0", {31'b0, id_ready}, 0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk($sformatf("hold_valid_%0d", c), {31'b0, ex_valid}, 1);
            chk($sformatf("hold_pc_%0d", c), ex_pc, 32'h200);
            chk($sformatf("hold_op1_%0d", c), ex_op1, 32'h2222_4444);
            chk($sformatf("hold_waddr_%0d", c), {27'b0, ex_waddr}, 5);
            if (c < 3) #1 chk($sformatf("hold_id_ready_%0d", c), {31'b0, id_ready}, 0);
        end
        ex_ready = 1;
        sb.push_back(mk(32'h204, 32'h2222_4444, 32'h2222_4444, 0, ALU_ADD, 0, 1, 6, 0));
        #1 chk("hold_release", {31'b0, id_ready}, 1);
        @(negedge clk);
        drive(0, 0, 0);

        // Flush with a load-use hazard present: no STALL entered
        @(negedge clk);
        drive(1, 32'h300, 32'h0013_8433);
        ex_fwd_we = 1; ex_fwd_addr = 7; ex_fwd_load = 1;
        flush = 1;
        #1 chk("flush_id_ready", {31'b0, id_ready}, 0);
        @(negedge clk);
        chk("flush_ex_valid", {31'b0, ex_valid}, 0);
        clear_fwd();
        flush = 0;
        drive(0, 0, 0);
        @(negedge clk);
        chk("flush_stall_cnt_a", stall_cnt, 1);
        @(negedge clk);
        chk("flush_stall_cnt_b", stall_cnt, 1);

        // Reset in the middle of HOLD
        drive(1, 32'h400, 32'h4041_84B3);
        sb.push_back(mk(32'h400, 32'h0303_0303, 32'h0404_0404, 0, ALU_SUB, 0, 1, 9, 0));
        @(negedge clk);
        drive(1, 32'h404, 32'h0001_02B3);
        ex_ready = 0;
        @(negedge clk);
        rst = 1;
        #1 chk("rst_hold_id_ready", {31'b0, id_ready}, 0);
        @(negedge clk);
        rst = 0;
        ex_ready = 1;
        drive(0, 0, 0);
        chk("rst_hold_ex_valid", {31'b0, ex_valid}, 0);
        chk("rst_hold_stall_cnt", stall_cnt, 0);
        #1 chk("rst_hold_id_ready_after", {31'b0, id_ready}, 1);

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
